hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It generates every hold, flush and bubble command for the PC, the IF/ID register and the ID/EX register. It arbitrates load-use stalls, data-memory wait states, taken branches, ID-stage jumps and interrupt entry through a small state machine, so that at most one pipeline action is in effect per cycle. It sits beside the decoder in ID and drives the control-bubble and clear inputs of the inter-stage registers.

## Interface
- DRAIN_CYCLES, 2: bubble cycles inserted before interrupt entry so EX/MEM/WB retire; legal 1..7.
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rt  in  5  load destination register in EX.
- IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID.
- IF_ID_UsesRt  in  1  ID instruction reads Rt (R-type, store, beq/bne).
- ID_Jump  in  1  J/JAL/JR/JALR resolved in ID.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- MemBusy  in  1  data memory not ready; MEM must hold.
- IRQ  in  1  level-sensitive external interrupt.
- KernelMode  in  1  PC[31] of the instruction in ID; interrupts are masked when set.
- PC_Write  out  1  PC may update.
- IF_ID_Write  out  1  IF/ID may load.
- IF_ID_Flush  out  1  IF/ID loads a NOP.
- ID_EX_Bubble  out  1  ID/EX loads zeroed control fields (data fields still load).
- EX_MEM_Hold  out  1  EX/MEM and MEM/WB keep their contents.
- IRQ_Take  out  1  one-cycle pulse; selects the interrupt vector at the PC mux.

## Operation
- States: RUN, LOAD_STALL, MEM_WAIT, IRQ_DRAIN, IRQ_ENTER. Reset enters RUN and clears the drain counter.
- Load-use hazard: ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
- Priority evaluated in RUN each cycle, highest first: MemBusy, EX_BranchTaken, IRQ&&!KernelMode, load-use, ID_Jump.
- RUN outputs: PC_Write=1, IF_ID_Write=1, all other outputs 0, except as modified by the condition that wins priority:
  - MemBusy: go to MEM_WAIT. Outputs this cycle: PC_Write=0, IF_ID_Write=0, EX_MEM_Hold=1, ID_EX_Bubble=0. ID/EX is frozen by the register enable path.
  - EX_BranchTaken: stay in RUN. Outputs: IF_ID_Flush=1, ID_EX_Bubble=1. Any simultaneous load-use, jump or IRQ is discarded this cycle.
  - IRQ: go to IRQ_DRAIN with drain counter=DRAIN_CYCLES-1. Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - load-use: go to LOAD_STALL. Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - ID_Jump: stay in RUN. Output: IF_ID_Flush=1.
- LOAD_STALL: outputs are the RUN defaults. Go to RUN unconditionally, so exactly one bubble is inserted per load-use. If MemBusy is asserted in this cycle, MEM_WAIT takes precedence.
- MEM_WAIT: holds all stages (PC_Write=0, IF_ID_Write=0, EX_MEM_Hold=1) while MemBusy=1. Returns to RUN the cycle after MemBusy falls. IRQ and branch are re-evaluated in RUN.
- IRQ_DRAIN: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Counter decrements each cycle; at 0, go to IRQ_ENTER. MemBusy freezes the counter and additionally asserts EX_MEM_Hold.
- IRQ_ENTER: IRQ_Take=1, PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1. Go to RUN. IRQ is not re-sampled until the next RUN cycle where KernelMode=0.
- IRQ deasserting during IRQ_DRAIN does not abort entry: the interrupt is committed once sampled.

## Timing
- All outputs are combinational from the current state and inputs; no output register. The next state is registered.
- Reset value, with reset high at the clock edge: state RUN. In the reset cycle the outputs are PC_Write=1, IF_ID_Write=1 and all others 0.
- Latencies:
  - Load-use: 1 stall cycle.
  - Taken branch: 2 flushed slots, IF/ID and ID/EX, in the same cycle.
  - Jump: 1 flushed slot.
  - IRQ: DRAIN_CYCLES+1 cycles from sampling to the IRQ_Take pulse.
- Reset asserted mid-drain or mid-wait returns to RUN on the next edge; no IRQ_Take is emitted.

## Configuration
- HAZARD_PERF_EN defined: adds output ports stall_count[31:0] and flush_count[31:0].
  - stall_count increments every cycle PC_Write=0.
  - flush_count increments every cycle IF_ID_Flush=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package pipe_pkg: the state enum hz_state_t (RUN=0, LOAD_STALL=1, MEM_WAIT=2, IRQ_DRAIN=3, IRQ_ENTER=4), REG_ZERO=5'd0, and the interrupt vector constant used with IRQ_Take.
- One sub-module, hazard_detect: purely the load-use comparator, reused by the forwarding unit.

## Test plan
- Load-use: lw $t0, then add $t1,$t0,$t2 (ID_EX_Rt=8, IF_ID_Rs=8, MemRead=1) -> exactly one cycle with PC_Write=0, ID_EX_Bubble=1, then RUN. The same sequence with Rt=0 -> no stall.
- Branch beats load-use: EX_BranchTaken=1 with a load-use hazard present in the same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, state stays RUN.
- MemBusy held 3 cycles -> EX_MEM_Hold=1 and PC_Write=0 for those 3 cycles plus the entry cycle; RUN on the cycle after MemBusy falls.
- IRQ, DRAIN_CYCLES=2, KernelMode=0 -> 2 bubble cycles, then IRQ_Take=1 for exactly one cycle. With KernelMode=1 -> IRQ ignored.
- IRQ drain with MemBusy pulsed for 2 cycles mid-drain -> counter frozen, IRQ_Take delayed by 2 cycles.
- Reset during IRQ_DRAIN -> next cycle RUN, IRQ_Take never asserted. With HAZARD_PERF_EN, both counters read 0 after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard controller states, register-zero index
// and the interrupt entry vector selected when IRQ_Take pulses.
package pipe_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    MEM_WAIT   = 3'd2,
    IRQ_DRAIN  = 3'd3,
    IRQ_ENTER  = 3'd4
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0180;
  localparam int          DRAIN_W    = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the ID
// instruction. Shared with the forwarding unit.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       uses_rt,
  output logic       load_use
);

  // $zero never carries a dependency, even when a load targets it
  assign load_use = mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: one hold/flush/bubble action per cycle.
// Optional HAZARD_PERF_EN adds stall_count / flush_count performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       IF_ID_UsesRt,
  input  logic       ID_Jump,
  input  logic       EX_BranchTaken,
  input  logic       MemBusy,
  input  logic       IRQ,
  input  logic       KernelMode,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       EX_MEM_Hold,
  output logic       IRQ_Take
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

  hz_state_t          state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               load_use;

  hazard_detect u_detect (
    .mem_read (ID_EX_MemRead),
    .ex_rt    (ID_EX_Rt),
    .id_rs    (IF_ID_Rs),
    .id_rt    (IF_ID_Rt),
    .uses_rt  (IF_ID_UsesRt),
    .load_use (load_use)
  );

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Hold  = 1'b0;
    IRQ_Take     = 1'b0;
    // Reset forces the free-running outputs regardless of the stale state
    if (reset) begin
      state_d = RUN;
      drain_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (MemBusy) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            EX_MEM_Hold = 1'b1;
            state_d     = MEM_WAIT;
          end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (IRQ && !KernelMode) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            drain_d      = DRAIN_INIT;
            state_d      = IRQ_DRAIN;
          end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            state_d      = LOAD_STALL;
          end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (MemBusy) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            EX_MEM_Hold = 1'b1;
            state_d     = MEM_WAIT;
          end else begin
            state_d = RUN;
          end
        end
        MEM_WAIT: begin
          // Hold through the cycle MemBusy drops; RUN resumes on the next one
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          EX_MEM_Hold = 1'b1;
          if (!MemBusy) state_d = RUN;
        end
        IRQ_DRAIN: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (MemBusy) begin
            EX_MEM_Hold = 1'b1;
          end else if (drain_q == '0) begin
            state_d = IRQ_ENTER;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        IRQ_ENTER: begin
          IRQ_Take     = 1'b1;
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q + {31'd0, ~PC_Write};
    flush_d = flush_q + {31'd0, IF_ID_Flush};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a stateful vector table plus reset and
// performance-counter sequences (the latter only when HAZARD_PERF_EN is defined).
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
  logic       IF_ID_UsesRt, ID_Jump, EX_BranchTaken, MemBusy, IRQ, KernelMode;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold, IRQ_Take;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_Rt       (ID_EX_Rt),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .IF_ID_UsesRt   (IF_ID_UsesRt),
    .ID_Jump        (ID_Jump),
    .EX_BranchTaken (EX_BranchTaken),
    .MemBusy        (MemBusy),
    .IRQ            (IRQ),
    .KernelMode     (KernelMode),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .EX_MEM_Hold    (EX_MEM_Hold),
    .IRQ_Take       (IRQ_Take)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  // Expected outputs packed as {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold, IRQ_Take}
  typedef struct {
    logic       busy, br, irq, km, mr;
    logic [4:0] ex_rt, rs, rt;
    logic       uses, jmp;
    logic [5:0] exp;
    hz_state_t  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic busy, logic br, logic irq, logic km, logic mr,
                             logic [4:0] ex_rt, logic [4:0] rs, logic [4:0] rt,
                             logic uses, logic jmp, logic [5:0] exp, hz_state_t st);
    vec_t r;
    r.busy = busy; r.br = br; r.irq = irq; r.km = km; r.mr = mr;
    r.ex_rt = ex_rt; r.rs = rs; r.rt = rt; r.uses = uses; r.jmp = jmp;
    r.exp = exp; r.st = st;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    MemBusy = x.busy; EX_BranchTaken = x.br; IRQ = x.irq; KernelMode = x.km;
    ID_EX_MemRead = x.mr; ID_EX_Rt = x.ex_rt; IF_ID_Rs = x.rs; IF_ID_Rt = x.rt;
    IF_ID_UsesRt = x.uses; ID_Jump = x.jmp;
  endtask

  function automatic logic [5:0] outs();
    return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold, IRQ_Take};
  endfunction

  vec_t idle;

  initial begin
    idle = v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b110000, RUN);

    // Load-use via Rs, then the same with Rt=0
    tbl.push_back(idle);
    tbl.push_back(v(0,0,0,0,1, 5'd8,5'd8,5'd0, 0,0, 6'b000100, RUN));
    tbl.push_back(v(0,0,0,0,1, 5'd8,5'd8,5'd0, 0,0, 6'b110000, LOAD_STALL));
    tbl.push_back(idle);
    tbl.push_back(v(0,0,0,0,1, 5'd0,5'd0,5'd0, 0,0, 6'b110000, RUN));
    // Load-use via Rt only when the ID instruction reads Rt
    tbl.push_back(v(0,0,0,0,1, 5'd9,5'd3,5'd9, 1,0, 6'b000100, RUN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b110000, LOAD_STALL));
    tbl.push_back(v(0,0,0,0,1, 5'd9,5'd3,5'd9, 0,0, 6'b110000, RUN));
    // Branch beats load-use, IRQ and jump; jump alone; masked IRQ
    tbl.push_back(v(0,1,1,0,1, 5'd8,5'd8,5'd0, 0,1, 6'b111100, RUN));
    tbl.push_back(idle);
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,1, 6'b111000, RUN));
    tbl.push_back(v(0,0,1,1,0, 5'd0,5'd0,5'd0, 0,0, 6'b110000, RUN));
    // MemBusy for three cycles
    tbl.push_back(v(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, RUN));
    tbl.push_back(v(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, MEM_WAIT));
    tbl.push_back(v(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, MEM_WAIT));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, MEM_WAIT));
    tbl.push_back(idle);
    // MemBusy beats branch
    tbl.push_back(v(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, RUN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000010, MEM_WAIT));
    tbl.push_back(idle);
    // IRQ, pulse deasserted after sampling: entry still committed
    tbl.push_back(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, RUN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b111101, IRQ_ENTER));
    tbl.push_back(idle);
    // IRQ with MemBusy for two cycles mid-drain
    tbl.push_back(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, RUN));
    tbl.push_back(v(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000110, IRQ_DRAIN));
    tbl.push_back(v(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000110, IRQ_DRAIN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b111101, IRQ_ENTER));
    tbl.push_back(idle);
    // IRQ beats load-use; level IRQ held, masked once in kernel mode
    tbl.push_back(v(0,0,1,0,1, 5'd8,5'd8,5'd0, 0,0, 6'b000100, RUN));
    tbl.push_back(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b000100, IRQ_DRAIN));
    tbl.push_back(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b111101, IRQ_ENTER));
    tbl.push_back(v(0,0,1,1,0, 5'd0,5'd0,5'd0, 0,0, 6'b110000, RUN));
    tbl.push_back(idle);

    // Reset state
    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'(6'b110000));
    @(negedge clk);
    chk("reset_state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_flush_count", flush_count, 32'd0);
`endif
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(tbl[i].st));
    end

    // Reset asserted mid-drain: back to RUN, no IRQ_Take afterwards
    @(negedge clk);
    drive(v(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0, 6'b0, RUN));
    @(negedge clk);
    drive(idle);
    #1;
    chk("drain_before_reset", 32'(dut.state_q), 32'(IRQ_DRAIN));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_drain_outs", 32'(outs()), 32'(6'b110000));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_reset_state", 32'(dut.state_q), 32'(RUN));
    chk("after_reset_outs", 32'(outs()), 32'(6'b110000));
`ifdef HAZARD_PERF_EN
    chk("perf_clear_stall", stall_count, 32'd0);
    chk("perf_clear_flush", flush_count, 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("no_take_%0d", k), 32'(IRQ_Take), 32'd0);
    end

`ifdef HAZARD_PERF_EN
    // One jump flush then one load-use stall
    @(negedge clk);
    drive(v(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,1, 6'b0, RUN));
    @(negedge clk);
    drive(v(0,0,0,0,1, 5'd8,5'd8,5'd0, 0,0, 6'b0, RUN));
    @(negedge clk);
    drive(idle);
    #1;
    chk("perf_flush_one", flush_count, 32'd1);
    chk("perf_stall_one", stall_count, 32'd1);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
